// File: rtl/bram_port_arb.sv
// BRAM port B arbiter: display reads have absolute priority, the processing
// engine fills idle cycles; read returns are tagged in order with RD_LAT latency.
module bram_port_arb #(
  parameter int unsigned MAX_ROW    = 540,
  parameter int unsigned MAX_COL    = 540,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_LIM = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_req_i,
  input  logic [18:0] disp_addr_i,
  output logic        disp_rvalid_o,
  output logic [7:0]  disp_rdata_o,
  input  logic        proc_req_i,
  input  logic        proc_we_i,
  input  logic [18:0] proc_addr_i,
  input  logic [7:0]  proc_wdata_i,
  output logic        proc_gnt_o,
  output logic        proc_rvalid_o,
  output logic [7:0]  proc_rdata_o,
  output logic        enb_o,
  output logic        web_o,
  output logic [18:0] addrb_o,
  output logic [7:0]  d2memb_o,
  input  logic [7:0]  mem2db_i,
  output logic        err_o,
  output logic        starve_o,
  input  logic        clr_i
);

  localparam logic [18:0] LAST_ADDR = 19'(MAX_ROW * MAX_COL - 1);
  localparam logic [15:0] WAIT_LIM  = 16'(STARVE_LIM);

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_PROC = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   blank;
  } tag_t;

  logic        disp_own;
  logic        proc_gnt;
  logic        access;
  logic        in_rng;
  logic [18:0] sel_addr;
  tag_t        tag_in;
  tag_t        tags [RD_LAT];
  tag_t        tag_out;
  logic [7:0]  ret_data;
  logic        disp_ret;
  logic        proc_ret;
  logic [15:0] wait_cnt;
  logic        err_q;
  logic        starve_q;

  always_comb begin
    disp_own = rst_n & disp_req_i;
    proc_gnt = rst_n & ~disp_req_i & proc_req_i;
    access   = disp_own | proc_gnt;
    sel_addr = '0;
    if (disp_own) begin
      sel_addr = disp_addr_i;
    end else if (proc_gnt) begin
      sel_addr = proc_addr_i;
    end
    in_rng       = sel_addr <= LAST_ADDR;
    tag_in.valid = disp_own | (proc_gnt & ~proc_we_i);
    tag_in.owner = disp_own ? OWN_DISP : OWN_PROC;
    tag_in.blank = ~in_rng;
  end

  assign proc_gnt_o = proc_gnt;
  assign enb_o      = access & in_rng;
  assign web_o      = proc_gnt & proc_we_i & in_rng;
  assign addrb_o    = sel_addr;
  assign d2memb_o   = (proc_gnt & proc_we_i) ? proc_wdata_i : '0;

  // Tag shift register pushed every cycle so its output lines up with BRAM data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0] <= tag_in;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  // Gated by rst_n so in-flight returns vanish during the reset cycle too.
  assign tag_out       = tags[RD_LAT-1];
  assign ret_data      = tag_out.blank ? '0 : mem2db_i;
  assign disp_ret      = rst_n & tag_out.valid & (tag_out.owner == OWN_DISP);
  assign proc_ret      = rst_n & tag_out.valid & (tag_out.owner == OWN_PROC);
  assign disp_rvalid_o = disp_ret;
  assign proc_rvalid_o = proc_ret;
  assign disp_rdata_o  = disp_ret ? ret_data : '0;
  assign proc_rdata_o  = proc_ret ? ret_data : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      if (!proc_req_i || proc_gnt) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LIM) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      err_q    <= (access & ~in_rng) | (err_q & ~clr_i);
      starve_q <= (wait_cnt == WAIT_LIM) | (starve_q & ~clr_i);
    end
  end

  assign err_o    = err_q;
  assign starve_o = starve_q;

endmodule

// File: tb/tb_bram_port_arb.sv
// Directed bench for bram_port_arb with a BRAM model and a read-return scoreboard.
module tb_bram_port_arb;

  logic        clk;
  logic        rst_n;
  logic        disp_req_i;
  logic [18:0] disp_addr_i;
  logic        disp_rvalid_o;
  logic [7:0]  disp_rdata_o;
  logic        proc_req_i;
  logic        proc_we_i;
  logic [18:0] proc_addr_i;
  logic [7:0]  proc_wdata_i;
  logic        proc_gnt_o;
  logic        proc_rvalid_o;
  logic [7:0]  proc_rdata_o;
  logic        enb_o;
  logic        web_o;
  logic [18:0] addrb_o;
  logic [7:0]  d2memb_o;
  logic [7:0]  mem2db_i;
  logic        err_o;
  logic        starve_o;
  logic        clr_i;

  bram_port_arb #(
    .MAX_ROW(540),
    .MAX_COL(540),
    .RD_LAT(2),
    .STARVE_LIM(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .disp_req_i(disp_req_i),
    .disp_addr_i(disp_addr_i),
    .disp_rvalid_o(disp_rvalid_o),
    .disp_rdata_o(disp_rdata_o),
    .proc_req_i(proc_req_i),
    .proc_we_i(proc_we_i),
    .proc_addr_i(proc_addr_i),
    .proc_wdata_i(proc_wdata_i),
    .proc_gnt_o(proc_gnt_o),
    .proc_rvalid_o(proc_rvalid_o),
    .proc_rdata_o(proc_rdata_o),
    .enb_o(enb_o),
    .web_o(web_o),
    .addrb_o(addrb_o),
    .d2memb_o(d2memb_o),
    .mem2db_i(mem2db_i),
    .err_o(err_o),
    .starve_o(starve_o),
    .clr_i(clr_i)
  );

  typedef struct {
    logic       port;
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t       sb [$];
  int         checks = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] bram [int];
  logic [7:0] shadow [int];
  logic [7:0] p0 = 8'h00;
  logic [7:0] p1 = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten locations read back as the low address byte.
  function automatic logic [7:0] bram_rd(input logic [18:0] a);
    if (bram.exists(int'(a))) return bram[int'(a)];
    return a[7:0];
  endfunction

  function automatic logic [7:0] shadow_rd(input logic [18:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return a[7:0];
  endfunction

  // Two-stage BRAM model; idle cycles return garbage to expose blanking faults.
  always @(posedge clk) begin
    if (enb_o && web_o) bram[int'(addrb_o)] = d2memb_o;
    p1 <= p0;
    p0 <= (enb_o && !web_o) ? bram_rd(addrb_o) : 8'hEE;
  end
  assign mem2db_i = p1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("return", {14'd0, disp_rvalid_o, proc_rvalid_o, disp_rdata_o, proc_rdata_o},
          {14'd0, !e.port, e.port, (e.port ? 8'h00 : e.data), (e.port ? e.data : 8'h00)});
    end else begin
      chk("no_return", {14'd0, disp_rvalid_o, proc_rvalid_o, disp_rdata_o, proc_rdata_o}, 32'd0);
    end
  end

  task automatic drive(input logic dr, input logic [18:0] da, input logic pr,
                       input logic pw, input logic [18:0] pa, input logic [7:0] pd);
    logic        own_d;
    logic        g;
    logic        rng;
    logic [18:0] a;
    exp_t        e;
    disp_req_i   = dr;
    disp_addr_i  = da;
    proc_req_i   = pr;
    proc_we_i    = pw;
    proc_addr_i  = pa;
    proc_wdata_i = pd;
    own_d = dr && rst_n;
    g     = !dr && pr && rst_n;
    a     = own_d ? da : (g ? pa : 19'd0);
    rng   = a < 19'd291600;
    e.due = cyc + 2;
    if (own_d) begin
      e.port = 1'b0;
      e.data = rng ? shadow_rd(da) : 8'h00;
      sb.push_back(e);
    end else if (g && !pw) begin
      e.port = 1'b1;
      e.data = rng ? shadow_rd(pa) : 8'h00;
      sb.push_back(e);
    end
    if (g && pw && rng) shadow[int'(pa)] = pd;
    #1;
    chk("gnt",    {31'd0, proc_gnt_o}, {31'd0, g});
    chk("enb",    {31'd0, enb_o},      {31'd0, (own_d || g) && rng});
    chk("web",    {31'd0, web_o},      {31'd0, g && pw && rng});
    chk("addrb",  {13'd0, addrb_o},    {13'd0, a});
    chk("d2memb", {24'd0, d2memb_o},   {24'd0, (g && pw) ? pd : 8'h00});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr_i = 1'b0;
    disp_req_i = 1'b0; disp_addr_i = '0;
    proc_req_i = 1'b0; proc_we_i = 1'b0; proc_addr_i = '0; proc_wdata_i = '0;
    @(posedge clk);
    #1;
    // Reset: proc request must not be granted, flags clear.
    for (int i = 0; i < 3; i++) drive(1'b1, 19'd3, 1'b1, 1'b0, 19'd4, 8'd0);
    chk("rst_err",    {31'd0, err_o},    32'd0);
    chk("rst_starve", {31'd0, starve_o}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Display stream 0..9.
    for (int i = 0; i < 10; i++) drive(1'b1, 19'(i), 1'b0, 1'b0, 19'd0, 8'd0);
    idle(3);

    // Proc read with display idle.
    drive(1'b0, 19'd0, 1'b1, 1'b0, 19'h00100, 8'd0);
    idle(3);

    // Contention, then the held write lands, then read-after-write.
    for (int i = 0; i < 3; i++) drive(1'b1, 19'(20 + i), 1'b1, 1'b1, 19'd5, 8'hA5);
    drive(1'b0, 19'd0, 1'b1, 1'b1, 19'd5, 8'hA5);
    drive(1'b0, 19'd0, 1'b1, 1'b0, 19'd5, 8'h00);
    idle(3);

    // Range boundary: last valid address, then first invalid one.
    drive(1'b1, 19'd291599, 1'b0, 1'b0, 19'd0, 8'd0);
    chk("err_inrange", {31'd0, err_o}, 32'd0);
    drive(1'b1, 19'd291600, 1'b0, 1'b0, 19'd0, 8'd0);
    chk("err_set", {31'd0, err_o}, 32'd1);
    idle(3);
    chk("err_sticky", {31'd0, err_o}, 32'd1);
    clr_i = 1'b1;
    idle(1);
    clr_i = 1'b0;
    chk("err_clr", {31'd0, err_o}, 32'd0);
    // Out-of-range proc write is consumed without a BRAM write; set beats clear.
    clr_i = 1'b1;
    drive(1'b0, 19'd0, 1'b1, 1'b1, 19'd300000, 8'h33);
    clr_i = 1'b0;
    chk("err_set_wins", {31'd0, err_o}, 32'd1);
    drive(1'b0, 19'd0, 1'b1, 1'b0, 19'd400000, 8'h00);
    idle(3);
    clr_i = 1'b1;
    idle(1);
    clr_i = 1'b0;
    chk("err_clr2", {31'd0, err_o}, 32'd0);

    // Starvation with STARVE_LIM=8.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 19'(100 + i), 1'b1, 1'b0, 19'd7, 8'd0);
      if (i == 6) chk("starve_early", {31'd0, starve_o}, 32'd0);
    end
    chk("starve_set", {31'd0, starve_o}, 32'd1);
    drive(1'b0, 19'd0, 1'b1, 1'b0, 19'd7, 8'd0);
    idle(3);
    chk("starve_sticky", {31'd0, starve_o}, 32'd1);
    clr_i = 1'b1;
    idle(1);
    clr_i = 1'b0;
    chk("starve_clr", {31'd0, starve_o}, 32'd0);

    // Reads in flight (last one out of range) when reset hits.
    for (int i = 0; i < 10; i++)
      drive(1'b1, (i == 9) ? 19'd291600 : 19'(200 + i), 1'b1, 1'b0, 19'd9, 8'd0);
    chk("pre_rst_err",    {31'd0, err_o},    32'd1);
    chk("pre_rst_starve", {31'd0, starve_o}, 32'd1);
    rst_n = 1'b0;
    sb.delete();
    drive(1'b0, 19'd0, 1'b1, 1'b0, 19'd9, 8'd0);
    rst_n = 1'b1;
    chk("post_rst_err",    {31'd0, err_o},    32'd0);
    chk("post_rst_starve", {31'd0, starve_o}, 32'd0);
    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
